cnt_checker: RTL and testbench
==============================

CNT_CHECKER -- requirements
Module: cnt_checker

Interface
REQ-001 The parameter LOCK_LEN SHALL default to 4; it is the number of consecutive valid increments required to lock (legal range 1-15).
REQ-002 The parameter ERR_MAX SHALL default to 3; it is the number of consecutive mismatches while locked that drops lock (legal range 1-15).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The port list SHALL be as follows:
- clk  input  1  rising-edge system clock
- rst  input  1  synchronous, active-high reset
- cnt_in  input  4  count value from the 4-bit free-running counter
- cnt_vld  input  1  cnt_in is sampled only when this is 1
- locked  output  1  sequence lock established
- err  output  1  one-cycle pulse per mismatch while locked
- err_cnt  output  8  total mismatches while locked, saturating
- wrap_cnt  output  8  15->0 wraps seen while locked, modulo 256

Function
REQ-005 The block SHALL evaluate a sample only on a rising clk edge with cnt_vld=1; with cnt_vld=0, no internal state or output changes, and err=0.
REQ-006 The block SHALL hold internal registers prev[3:0], have_prev, run[3:0], miss[3:0] and a state (HUNT, LOCKED).
REQ-007 A sample SHALL match when have_prev=1 and cnt_in == (prev+1) mod 16, so that 15->0 is a legal increment.
REQ-008 On every evaluated sample, prev SHALL load cnt_in and have_prev SHALL set to 1, whether or not the sample matches.
REQ-009 The first evaluated sample after reset SHALL only load prev; it SHALL NOT be counted as a match or a mismatch.
REQ-010 In HUNT, the block SHALL handle samples as follows:
- match: run increments.
- mismatch: run clears to 0.
- err SHALL NOT assert in HUNT.
- err_cnt and wrap_cnt SHALL NOT change in HUNT.
REQ-011 HUNT->LOCKED SHALL occur on the match that brings run to LOCK_LEN; at that point, locked=1, run=0, miss=0.
REQ-012 In LOCKED, a match SHALL clear miss to 0.
REQ-013 In LOCKED, a match with cnt_in=0 SHALL also increment wrap_cnt, wrapping 255->0.
REQ-014 In LOCKED, a mismatch SHALL do all of the following:
- assert err for exactly the following cycle;
- increment err_cnt, saturating at 255;
- increment miss.
REQ-015 LOCKED->HUNT SHALL occur on the mismatch that brings miss to ERR_MAX; at that point, locked=0, run=0, miss=0.
REQ-016 The mismatch that causes LOCKED->HUNT SHALL still pulse err and count in err_cnt.
REQ-017 All outputs SHALL be registered; each output reflects a sample in the cycle after the edge that samples it (latency 1).
REQ-018 Back-to-back valid samples SHALL each be evaluated; consecutive mismatches SHALL produce err=1 on consecutive cycles.
REQ-019 The locked output SHALL change only on the transition edges defined in REQ-011 and REQ-015.

Reset
REQ-020 When rst=1 at a rising clk edge, the block SHALL set:
- state=HUNT;
- locked=0, err=0, err_cnt=0, wrap_cnt=0;
- prev=0, have_prev=0, run=0, miss=0.
REQ-021 rst SHALL take priority over cnt_vld; a sample presented in the same cycle as rst SHALL be discarded.
REQ-022 Reset mid-operation SHALL discard lock and all counts; relock SHALL require a fresh first sample plus LOCK_LEN matches.

Verification
REQ-023 The bench SHALL cover these directed scenarios, with default parameters:
- Lock: cnt_in 0,1,2,3,4 with cnt_vld=1 every cycle -> locked=1 in the cycle after the sample of 4; err stays 0.
- Wrap: while locked, drive 14,15,0,1 -> wrap_cnt increments 0->1 after the sample of 0; err stays 0.
- Single error: while locked, drive 5,6,9,10 -> one err pulse after the sample of 9; err_cnt=1; locked stays 1; the sample of 10 matches.
- Loss of lock: while locked, drive 3 consecutive mismatches (e.g. 7,0,7,0 after prev=6) -> err pulses on 3 consecutive cycles; err_cnt +3; locked=0 after the third.
- Valid gaps: 0,1,2 with cnt_vld=0 for 5 cycles, then 3,4 -> the gap causes no err; locked=1 after the sample of 4.
- Reset mid-lock: assert rst for 1 cycle while locked with err_cnt=2 -> next cycle locked=0, err_cnt=0, wrap_cnt=0; the next sample of 8 is load-only.

Source files
------------

// File: rtl/cnt_checker.sv
// Sequence checker for a 4-bit free-running counter: hunts for LOCK_LEN consecutive
// increments, then flags and counts mismatches and wraps until ERR_MAX misses in a row.
module cnt_checker #(
  parameter int unsigned LOCK_LEN = 4,
  parameter int unsigned ERR_MAX  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cnt_in,
  input  logic       cnt_vld,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic [7:0] wrap_cnt
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [4:0] LOCK_LEN_C = 5'(LOCK_LEN);
  localparam logic [4:0] ERR_MAX_C  = 5'(ERR_MAX);

  state_e     state_q, state_d;
  logic [3:0] prev_q, prev_d;
  logic       have_prev_q, have_prev_d;
  logic [3:0] run_q, run_d;
  logic [3:0] miss_q, miss_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [7:0] wrap_cnt_q, wrap_cnt_d;

  logic [3:0] prev_inc;
  logic [4:0] run_inc;
  logic [4:0] miss_inc;
  logic       match;

  // 4-bit addition wraps, so 15 -> 0 counts as a legal increment.
  assign prev_inc = prev_q + 4'd1;
  assign run_inc  = {1'b0, run_q} + 5'd1;
  assign miss_inc = {1'b0, miss_q} + 5'd1;
  assign match    = have_prev_q && (cnt_in == prev_inc);

  always_comb begin
    // NOTE: every _d gets a default before any branch; a path that leaves one
    // unassigned would infer a latch.
    state_d     = state_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    run_d       = run_q;
    miss_d      = miss_q;
    locked_d    = locked_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    wrap_cnt_d  = wrap_cnt_q;

    if (cnt_vld) begin
      prev_d      = cnt_in;
      have_prev_d = 1'b1;

      // The very first sample only seeds prev; it is neither match nor mismatch.
      if (have_prev_q) begin
        unique case (state_q)
          HUNT: begin
            if (match) begin
              if (run_inc == LOCK_LEN_C) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
                run_d    = 4'd0;
                miss_d   = 4'd0;
              end else begin
                run_d = run_inc[3:0];
              end
            end else begin
              run_d = 4'd0;
            end
          end

          LOCKED: begin
            if (match) begin
              miss_d = 4'd0;
              if (cnt_in == 4'd0) begin
                wrap_cnt_d = wrap_cnt_q + 8'd1;
              end
            end else begin
              err_d = 1'b1;
              if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
              end
              if (miss_inc == ERR_MAX_C) begin
                state_d  = HUNT;
                locked_d = 1'b0;
                run_d    = 4'd0;
                miss_d   = 4'd0;
              end else begin
                miss_d = miss_inc[3:0];
              end
            end
          end

          default: state_d = HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= HUNT;
      prev_q      <= 4'd0;
      have_prev_q <= 1'b0;
      run_q       <= 4'd0;
      miss_q      <= 4'd0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
      wrap_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
    end
  end

  assign locked   = locked_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;
  assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_cnt_checker.sv
// Directed bench for cnt_checker: each task drives a hand-computed step table
// and compares {locked, err, err_cnt, wrap_cnt} one cycle after each edge.
module tb_cnt_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] cnt_in = 4'd0;
  logic       cnt_vld = 1'b0;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;
  logic [7:0] wrap_cnt;

  int n_checks = 0;
  int n_errors = 0;

  cnt_checker dut (
    .clk      (clk),
    .rst      (rst),
    .cnt_in   (cnt_in),
    .cnt_vld  (cnt_vld),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt),
    .wrap_cnt (wrap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       vld;
    logic [3:0] v;
    logic       lk;
    logic       er;
    logic [7:0] ec;
    logic [7:0] wc;
  } step_t;

  function automatic step_t mk(input logic vld, input logic [3:0] v, input logic lk,
                               input logic er, input logic [7:0] ec, input logic [7:0] wc);
    step_t s;
    s.vld = vld; s.v = v; s.lk = lk; s.er = er; s.ec = ec; s.wc = wc;
    return s;
  endfunction

  // One clock: present the input, let the edge take it, then settle 1 time unit.
  task automatic cycle(input logic vld, input logic [3:0] v);
    cnt_vld = vld;
    cnt_in  = v;
    @(posedge clk);
    #1;
    cnt_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    cnt_vld = 1'b1;
    cnt_in  = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    cnt_vld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({locked, err, err_cnt, wrap_cnt} !== {1'b0, 1'b0, 8'd0, 8'd0}) begin
        n_errors++;
        $display("FAIL reset cycle %0d: locked=%b err=%b err_cnt=%0d wrap_cnt=%0d, expected all zero",
                 i, locked, err, err_cnt, wrap_cnt);
      end
      if (i == 0) cycle(1'b0, 4'd0);
    end
  endtask

  task automatic test_lock();
    step_t q[$];
    for (int v = 0; v < 4; v++) q.push_back(mk(1'b1, 4'(v), 1'b0, 1'b0, 8'd0, 8'd0));
    q.push_back(mk(1'b1, 4'd4, 1'b1, 1'b0, 8'd0, 8'd0));
    foreach (q[i]) begin
      cycle(q[i].vld, q[i].v);
      n_checks++;
      if ({locked, err, err_cnt, wrap_cnt} !== {q[i].lk, q[i].er, q[i].ec, q[i].wc}) begin
        n_errors++;
        $display("FAIL lock step %0d (cnt_in=%0d): locked=%b err=%b err_cnt=%0d wrap_cnt=%0d, expected locked=%b err=%b err_cnt=%0d wrap_cnt=%0d",
                 i, q[i].v, locked, err, err_cnt, wrap_cnt, q[i].lk, q[i].er, q[i].ec, q[i].wc);
      end
    end
  endtask

  task automatic test_wrap();
    step_t q[$];
    for (int v = 5; v <= 15; v++) q.push_back(mk(1'b1, 4'(v), 1'b1, 1'b0, 8'd0, 8'd0));
    q.push_back(mk(1'b1, 4'd0, 1'b1, 1'b0, 8'd0, 8'd1));
    q.push_back(mk(1'b1, 4'd1, 1'b1, 1'b0, 8'd0, 8'd1));
    foreach (q[i]) begin
      cycle(q[i].vld, q[i].v);
      n_checks++;
      if ({locked, err, err_cnt, wrap_cnt} !== {q[i].lk, q[i].er, q[i].ec, q[i].wc}) begin
        n_errors++;
        $display("FAIL wrap step %0d (cnt_in=%0d): locked=%b err=%b err_cnt=%0d wrap_cnt=%0d, expected locked=%b err=%b err_cnt=%0d wrap_cnt=%0d",
                 i, q[i].v, locked, err, err_cnt, wrap_cnt, q[i].lk, q[i].er, q[i].ec, q[i].wc);
      end
    end
  endtask

  task automatic test_single_error();
    step_t q[$];
    for (int v = 2; v <= 6; v++) q.push_back(mk(1'b1, 4'(v), 1'b1, 1'b0, 8'd0, 8'd1));
    q.push_back(mk(1'b1, 4'd9,  1'b1, 1'b1, 8'd1, 8'd1));
    q.push_back(mk(1'b1, 4'd10, 1'b1, 1'b0, 8'd1, 8'd1));
    foreach (q[i]) begin
      cycle(q[i].vld, q[i].v);
      n_checks++;
      if ({locked, err, err_cnt, wrap_cnt} !== {q[i].lk, q[i].er, q[i].ec, q[i].wc}) begin
        n_errors++;
        $display("FAIL single_error step %0d (cnt_in=%0d): locked=%b err=%b err_cnt=%0d wrap_cnt=%0d, expected locked=%b err=%b err_cnt=%0d wrap_cnt=%0d",
                 i, q[i].v, locked, err, err_cnt, wrap_cnt, q[i].lk, q[i].er, q[i].ec, q[i].wc);
      end
    end
  endtask

  // Consecutive mismatches: err on back-to-back cycles, lock drops on the third.
  task automatic test_back_to_back();
    step_t q[$];
    for (int v = 11; v <= 15; v++) q.push_back(mk(1'b1, 4'(v), 1'b1, 1'b0, 8'd1, 8'd1));
    q.push_back(mk(1'b1, 4'd0, 1'b1, 1'b0, 8'd1, 8'd2));
    for (int v = 1; v <= 7; v++) q.push_back(mk(1'b1, 4'(v), 1'b1, 1'b0, 8'd1, 8'd2));
    q.push_back(mk(1'b1, 4'd0, 1'b1, 1'b1, 8'd2, 8'd2));
    q.push_back(mk(1'b1, 4'd7, 1'b1, 1'b1, 8'd3, 8'd2));
    q.push_back(mk(1'b1, 4'd0, 1'b0, 1'b1, 8'd4, 8'd2));
    q.push_back(mk(1'b0, 4'd1, 1'b0, 1'b0, 8'd4, 8'd2));
    q.push_back(mk(1'b1, 4'd5, 1'b0, 1'b0, 8'd4, 8'd2));
    foreach (q[i]) begin
      cycle(q[i].vld, q[i].v);
      n_checks++;
      if ({locked, err, err_cnt, wrap_cnt} !== {q[i].lk, q[i].er, q[i].ec, q[i].wc}) begin
        n_errors++;
        $display("FAIL back_to_back step %0d (cnt_in=%0d): locked=%b err=%b err_cnt=%0d wrap_cnt=%0d, expected locked=%b err=%b err_cnt=%0d wrap_cnt=%0d",
                 i, q[i].v, locked, err, err_cnt, wrap_cnt, q[i].lk, q[i].er, q[i].ec, q[i].wc);
      end
    end
  endtask

  task automatic test_valid_gaps();
    step_t q[$];
    for (int v = 0; v <= 2; v++) q.push_back(mk(1'b1, 4'(v), 1'b0, 1'b0, 8'd4, 8'd2));
    for (int k = 0; k < 5; k++) q.push_back(mk(1'b0, 4'd9, 1'b0, 1'b0, 8'd4, 8'd2));
    q.push_back(mk(1'b1, 4'd3, 1'b0, 1'b0, 8'd4, 8'd2));
    q.push_back(mk(1'b1, 4'd4, 1'b1, 1'b0, 8'd4, 8'd2));
    foreach (q[i]) begin
      cycle(q[i].vld, q[i].v);
      n_checks++;
      if ({locked, err, err_cnt, wrap_cnt} !== {q[i].lk, q[i].er, q[i].ec, q[i].wc}) begin
        n_errors++;
        $display("FAIL valid_gaps step %0d (cnt_in=%0d): locked=%b err=%b err_cnt=%0d wrap_cnt=%0d, expected locked=%b err=%b err_cnt=%0d wrap_cnt=%0d",
                 i, q[i].v, locked, err, err_cnt, wrap_cnt, q[i].lk, q[i].er, q[i].ec, q[i].wc);
      end
    end
  endtask

  task automatic test_reset_mid_lock();
    step_t q[$];
    step_t r[$];
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int v = 0; v < 4; v++) q.push_back(mk(1'b1, 4'(v), 1'b0, 1'b0, 8'd0, 8'd0));
    q.push_back(mk(1'b1, 4'd4,  1'b1, 1'b0, 8'd0, 8'd0));
    q.push_back(mk(1'b1, 4'd9,  1'b1, 1'b1, 8'd1, 8'd0));
    q.push_back(mk(1'b1, 4'd10, 1'b1, 1'b0, 8'd1, 8'd0));
    q.push_back(mk(1'b1, 4'd0,  1'b1, 1'b1, 8'd2, 8'd0));
    for (int v = 1; v <= 15; v++) q.push_back(mk(1'b1, 4'(v), 1'b1, 1'b0, 8'd2, 8'd0));
    q.push_back(mk(1'b1, 4'd0,  1'b1, 1'b0, 8'd2, 8'd1));
    foreach (q[i]) begin
      cycle(q[i].vld, q[i].v);
      n_checks++;
      if ({locked, err, err_cnt, wrap_cnt} !== {q[i].lk, q[i].er, q[i].ec, q[i].wc}) begin
        n_errors++;
        $display("FAIL relock_setup step %0d (cnt_in=%0d): locked=%b err=%b err_cnt=%0d wrap_cnt=%0d, expected locked=%b err=%b err_cnt=%0d wrap_cnt=%0d",
                 i, q[i].v, locked, err, err_cnt, wrap_cnt, q[i].lk, q[i].er, q[i].ec, q[i].wc);
      end
    end

    // A sample of 7 during reset must be dropped, so 8 afterwards is load-only.
    rst     = 1'b1;
    cnt_vld = 1'b1;
    cnt_in  = 4'd7;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    cnt_vld = 1'b0;
    n_checks++;
    if ({locked, err, err_cnt, wrap_cnt} !== {1'b0, 1'b0, 8'd0, 8'd0}) begin
      n_errors++;
      $display("FAIL reset_mid_lock: locked=%b err=%b err_cnt=%0d wrap_cnt=%0d, expected all zero",
               locked, err, err_cnt, wrap_cnt);
    end

    for (int v = 8; v <= 11; v++) r.push_back(mk(1'b1, 4'(v), 1'b0, 1'b0, 8'd0, 8'd0));
    r.push_back(mk(1'b1, 4'd12, 1'b1, 1'b0, 8'd0, 8'd0));
    foreach (r[i]) begin
      cycle(r[i].vld, r[i].v);
      n_checks++;
      if ({locked, err, err_cnt, wrap_cnt} !== {r[i].lk, r[i].er, r[i].ec, r[i].wc}) begin
        n_errors++;
        $display("FAIL relock step %0d (cnt_in=%0d): locked=%b err=%b err_cnt=%0d wrap_cnt=%0d, expected locked=%b err=%b err_cnt=%0d wrap_cnt=%0d",
                 i, r[i].v, locked, err, err_cnt, wrap_cnt, r[i].lk, r[i].er, r[i].ec, r[i].wc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_single_error();
    test_back_to_back();
    test_valid_gaps();
    test_reset_mid_lock();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
